// File: rtl/ifmap_ram_loader_if.sv
// Stream-in / RAM-write bundle for the ifmap RAM loader.
// master = producer/controller side, slave = the loader itself.
`timescale 1ns/1ps
interface ifmap_ram_loader_if #(
    parameter int unsigned COLS = 13,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 5
) ();
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [DW-1:0]   in_data_ch0;
    logic [DW-1:0]   in_data_ch1;
    logic [DW-1:0]   in_data_ch2;
    logic [AW-1:0]   addr_write;
    logic [COLS-1:0] write_enable;
    logic [DW-1:0]   data_out_ch0;
    logic [DW-1:0]   data_out_ch1;
    logic [DW-1:0]   data_out_ch2;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, in_valid, in_last, in_data_ch0, in_data_ch1, in_data_ch2,
        input  in_ready, addr_write, write_enable, data_out_ch0, data_out_ch1, data_out_ch2,
        input  busy, done, err
    );

    modport slave (
        input  start, in_valid, in_last, in_data_ch0, in_data_ch1, in_data_ch2,
        output in_ready, addr_write, write_enable, data_out_ch0, data_out_ch1, data_out_ch2,
        output busy, done, err
    );
endinterface

// File: rtl/ifmap_ram_loader.sv
// Turns a row-major 3-channel pixel stream into one-hot bank writes for the ifmap RAM,
// then pulses done once the whole COLS x ROWS frame has been written.
`timescale 1ns/1ps
module ifmap_ram_loader #(
    parameter int unsigned COLS = 13,
    parameter int unsigned ROWS = 19,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 5
) (
    input logic              clk,
    input logic              rst,
    ifmap_ram_loader_if.slave bus
);
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   row_q, row_d;
    logic            err_q, err_d;
    logic [COLS-1:0] we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   d0_q, d0_d;
    logic [DW-1:0]   d1_q, d1_d;
    logic [DW-1:0]   d2_q, d2_d;
    logic            last_beat;

    assign last_beat = (row_q == AW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        we_d    = '0;
        addr_d  = addr_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    col_d   = '0;
                    row_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    we_d   = COLS'(1) << col_q;
                    addr_d = row_q;
                    d0_d   = bus.in_data_ch0;
                    d1_d   = bus.in_data_ch1;
                    d2_d   = bus.in_data_ch2;
                    // Framing error is flagged but never alters counting.
                    if (bus.in_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    // Ready is purely state-decoded so the producer never sees a valid->ready loop.
    assign bus.in_ready     = (state_q == StLoad);
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.err          = err_q;
    assign bus.write_enable = we_q;
    assign bus.addr_write   = addr_q;
    assign bus.data_out_ch0 = d0_q;
    assign bus.data_out_ch1 = d1_q;
    assign bus.data_out_ch2 = d2_q;
endmodule
